// File: rtl/audio_avg_filter.sv
// Per-channel moving-average filter sitting between the audio CODEC read and write ports.
// One stereo sample is in flight at a time: read it, accumulate it, then write the average back.
module audio_avg_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2N  = 3
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              bypass,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic              write_ready,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right
);

    localparam int N     = 1 << LOG2N;
    localparam int SUM_W = DATA_W + LOG2N;

    typedef enum logic [1:0] {
        S_RD,
        S_ACC,
        S_WR
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  x_l_q, x_l_d;
    logic [DATA_W-1:0]  x_r_q, x_r_d;
    logic [SUM_W-1:0]   sum_l_q, sum_l_d;
    logic [SUM_W-1:0]   sum_r_q, sum_r_d;
    logic [DATA_W-1:0]  dly_l_q [N];
    logic [DATA_W-1:0]  dly_l_d [N];
    logic [DATA_W-1:0]  dly_r_q [N];
    logic [DATA_W-1:0]  dly_r_d [N];
    logic [LOG2N-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  wd_l_q, wd_l_d;
    logic [DATA_W-1:0]  wd_r_q, wd_r_d;
    logic [SUM_W-1:0]   sum_l_new;
    logic [SUM_W-1:0]   sum_r_new;

    function automatic logic [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{LOG2N{v[DATA_W-1]}}, v};
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RD;
            x_l_q   <= '0;
            x_r_q   <= '0;
            sum_l_q <= '0;
            sum_r_q <= '0;
            dly_l_q <= '{default: '0};
            dly_r_q <= '{default: '0};
            ptr_q   <= '0;
            wd_l_q  <= '0;
            wd_r_q  <= '0;
        end else begin
            state_q <= state_d;
            x_l_q   <= x_l_d;
            x_r_q   <= x_r_d;
            sum_l_q <= sum_l_d;
            sum_r_q <= sum_r_d;
            dly_l_q <= dly_l_d;
            dly_r_q <= dly_r_d;
            ptr_q   <= ptr_d;
            wd_l_q  <= wd_l_d;
            wd_r_q  <= wd_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RD:    if (read_ready) state_d = S_ACC;
            S_ACC:   state_d = S_WR;
            S_WR:    if (write_ready) state_d = S_RD;
            default: state_d = S_RD;
        endcase
    end

    // Handshakes are gated by resetn so nothing pulses while the block is held in reset.
    always_comb begin
        read  = resetn && (state_q == S_RD) && read_ready;
        write = resetn && (state_q == S_WR) && write_ready;
    end

    always_comb begin
        x_l_d     = x_l_q;
        x_r_d     = x_r_q;
        sum_l_d   = sum_l_q;
        sum_r_d   = sum_r_q;
        dly_l_d   = dly_l_q;
        dly_r_d   = dly_r_q;
        ptr_d     = ptr_q;
        wd_l_d    = wd_l_q;
        wd_r_d    = wd_r_q;
        sum_l_new = sum_l_q + sext(x_l_q) - sext(dly_l_q[ptr_q]);
        sum_r_new = sum_r_q + sext(x_r_q) - sext(dly_r_q[ptr_q]);

        if (state_q == S_RD && read_ready) begin
            x_l_d = readdata_left;
            x_r_d = readdata_right;
        end

        // The top DATA_W bits of the sum are exactly the low DATA_W bits of sum >>> LOG2N.
        if (state_q == S_ACC) begin
            sum_l_d        = sum_l_new;
            sum_r_d        = sum_r_new;
            dly_l_d[ptr_q] = x_l_q;
            dly_r_d[ptr_q] = x_r_q;
            ptr_d          = ptr_q + 1'b1;
            wd_l_d         = bypass ? x_l_q : sum_l_new[SUM_W-1:LOG2N];
            wd_r_d         = bypass ? x_r_q : sum_r_new[SUM_W-1:LOG2N];
        end
    end

    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed bench for audio_avg_filter (DATA_W=24, LOG2N=3): handshake timing, ramp-up,
// full-scale averaging, write back-pressure, bypass and reset in the middle of a sample.
module tb_audio_avg_filter;

    logic        clk;
    logic        resetn;
    logic        bypass;
    logic        read_ready;
    logic [23:0] readdata_left;
    logic [23:0] readdata_right;
    logic        write_ready;
    logic        read;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;

    int checks;
    int errors;

    longint winL [8];
    longint winR [8];
    int     mPtr;

    audio_avg_filter #(.DATA_W(24), .LOG2N(3)) dut (
        .CLOCK_50        (clk),
        .resetn          (resetn),
        .bypass          (bypass),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write_ready     (write_ready),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            winL[i] = 0;
            winR[i] = 0;
        end
        mPtr = 0;
    endtask

    // Reference: plain window average with floor division, raw sample when bypassed.
    task automatic modelPush(input logic [23:0] l, input logic [23:0] r, input logic byp,
                             output logic [23:0] expL, output logic [23:0] expR);
        longint sL;
        longint sR;
        winL[mPtr] = longint'($signed(l));
        winR[mPtr] = longint'($signed(r));
        mPtr = (mPtr + 1) % 8;
        sL = 0;
        sR = 0;
        for (int i = 0; i < 8; i++) begin
            sL += winL[i];
            sR += winR[i];
        end
        sL = sL >>> 3;
        sR = sR >>> 3;
        expL = byp ? l : sL[23:0];
        expR = byp ? r : sR[23:0];
    endtask

    task automatic waitFor(input logic wantWrite, output int cycles);
        cycles = 0;
        #1;
        while (((wantWrite ? write : read) == 1'b0) && cycles < 100) begin
            @(negedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic resetDut();
        resetn      = 1'b0;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        bypass      = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One full sample with both ready lines high: read, accumulate, write, 3-cycle period.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input string tag);
        logic [23:0] expL;
        logic [23:0] expR;
        int          waited;
        modelPush(l, r, bypass, expL, expR);
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        waitFor(1'b0, waited);
        checkOutput({tag, ".rdWait"}, waited, 0);
        checkOutput({tag, ".rdOnly"}, {read, write}, 2'b10);
        @(negedge clk);
        #1;
        checkOutput({tag, ".accIdle"}, {read, write}, 2'b00);
        @(negedge clk);
        waitFor(1'b1, waited);
        checkOutput({tag, ".wrWait"}, waited, 0);
        checkOutput({tag, ".wrOnly"}, {read, write}, 2'b01);
        checkOutput({tag, ".left"}, writedata_left, expL);
        checkOutput({tag, ".right"}, writedata_right, expR);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int bad;
        checks = 0;
        errors = 0;
        modelReset();
        bypass         = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        resetn         = 1'b1;
        #1 resetn = 1'b0;

        // Test 1: outputs quiet in reset even with both ready lines high.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t1.rstHandshake", {read, write}, 2'b00);
        checkOutput("t1.rstLeft", writedata_left, 24'h0);
        checkOutput("t1.rstRight", writedata_right, 24'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("t1.readAfterRelease", {read, write}, 2'b10);
        read_ready = 1'b0;
        @(negedge clk);

        // Test 2: ramp of a constant 0x000800 input.
        resetDut();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(24'h000800, 24'h000800, $sformatf("t2.s%0d", k));
            checkOutput($sformatf("t2.hand%0d", k), writedata_left, (k < 8 ? k : 8) * 32'h100);
        end

        // Test 3: negative constant then full-scale positive.
        resetDut();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(24'hFFFFF8, 24'hFFFFF8, $sformatf("t3.neg%0d", k));
            if (k == 1) checkOutput("t3.firstNeg", writedata_left, 24'hFFFFFF);
        end
        checkOutput("t3.fullNeg", writedata_right, 24'hFFFFF8);
        for (int k = 1; k <= 8; k++)
            applyStimulus(24'h7FFFFF, 24'h7FFFFF, $sformatf("t3.max%0d", k));
        checkOutput("t3.maxL", writedata_left, 24'h7FFFFF);
        checkOutput("t3.maxR", writedata_right, 24'h7FFFFF);

        // Test 4: write back-pressure blocks further reads.
        resetDut();
        readdata_left  = 24'h000800;
        readdata_right = 24'h000800;
        read_ready     = 1'b1;
        write_ready    = 1'b0;
        waitFor(1'b0, waited);
        checkOutput("t4.read", {read, write}, 2'b10);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (read || write) bad++;
        end
        checkOutput("t4.heldIdle", bad, 0);
        write_ready = 1'b1;
        #1;
        checkOutput("t4.wrPulse", {read, write}, 2'b01);
        checkOutput("t4.data", writedata_left, 24'h000100);
        @(negedge clk);
        #1;
        checkOutput("t4.readNext", {read, write}, 2'b10);
        read_ready = 1'b0;
        @(negedge clk);

        // Test 5: bypass passes raw samples while the window keeps filling.
        resetDut();
        bypass = 1'b1;
        for (int k = 1; k <= 8; k++)
            applyStimulus(24'h123456, 24'hABCDEF, $sformatf("t5.byp%0d", k));
        checkOutput("t5.rawL", writedata_left, 24'h123456);
        checkOutput("t5.rawR", writedata_right, 24'hABCDEF);
        bypass = 1'b0;
        applyStimulus(24'h000000, 24'h000000, "t5.avg");
        checkOutput("t5.avgL", writedata_left, 24'h0FEDCB);
        checkOutput("t5.avgR", writedata_right, 24'hB65431);

        // Test 6: reset while waiting to write drops the sample and clears the sums.
        resetDut();
        for (int k = 1; k <= 3; k++)
            applyStimulus(24'h000800, 24'h000800, $sformatf("t6.pre%0d", k));
        readdata_left  = 24'h400000;
        readdata_right = 24'h400000;
        read_ready     = 1'b1;
        write_ready    = 1'b0;
        waitFor(1'b0, waited);
        checkOutput("t6.read", {read, write}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("t6.inWr", {read, write}, 2'b00);
        resetn      = 1'b0;
        write_ready = 1'b1;
        #1;
        checkOutput("t6.rstQuiet", {read, write}, 2'b00);
        checkOutput("t6.rstData", writedata_left, 24'h0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (write) bad++;
        end
        checkOutput("t6.noWrite", bad, 0);
        @(negedge clk);
        read_ready = 1'b0;
        modelReset();
        resetn = 1'b1;
        applyStimulus(24'h000800, 24'h000800, "t6.post");
        checkOutput("t6.cleared", writedata_left, 24'h000100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
